// File: rtl/tri_dispatch.sv
// rtl/tri_dispatch.sv - triangle FIFO with round-robin dispatch to setup+rasterizer lanes
// Each lane sequences setup -> rasterize; degenerate triangles return the lane to idle.
module tri_dispatch #(
    parameter int NUM_LANES  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TRI_W      = 96,  // three packed 32-bit vertices {v2,v1,v0}
    parameter int CNT_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [TRI_W-1:0]               tri_in,
    input  logic                           tri_valid,
    output logic                           tri_ready,
    input  logic                           flush,
    input  logic                           in_order,
    output logic [NUM_LANES*TRI_W-1:0]     lane_tri,
    output logic [NUM_LANES-1:0]           setup_start,
    input  logic [NUM_LANES-1:0]           setup_done,
    input  logic [NUM_LANES-1:0]           setup_valid,
    output logic [NUM_LANES-1:0]           rast_start,
    input  logic [NUM_LANES-1:0]           rast_done,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic [NUM_LANES-1:0]           lane_busy,
    output logic [CNT_W-1:0]               tri_done_cnt,
    output logic [CNT_W-1:0]               degen_cnt,
    output logic                           busy
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LVW = PW + 1;
    localparam int LW  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {L_IDLE, L_SETUP, L_RAST} lane_state_e;

    lane_state_e          state_q    [NUM_LANES];
    lane_state_e          state_d    [NUM_LANES];
    logic [TRI_W-1:0]     lane_tri_q [NUM_LANES];
    logic [TRI_W-1:0]     lane_tri_d [NUM_LANES];
    logic [TRI_W-1:0]     mem_q      [FIFO_DEPTH];
    logic [TRI_W-1:0]     mem_d      [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVW-1:0]       level_q, level_d;
    logic [LW-1:0]        rr_q, rr_d;
    logic [NUM_LANES-1:0] setup_start_q, setup_start_d, rast_start_q, rast_start_d;
    logic [CNT_W-1:0]     done_cnt_q, done_cnt_d, degen_cnt_q, degen_cnt_d;
    logic [CNT_W-1:0]     done_inc, degen_inc;

    logic [NUM_LANES-1:0] idle_vec;
    logic                 fifo_full, fifo_empty, push, dispatch, pick_found;
    logic [LW-1:0]        pick_idx;
    int                   lane_idx;

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            idle_vec[i] = (state_q[i] == L_IDLE);
        end
    end

    assign fifo_full  = (level_q == LVW'(FIFO_DEPTH));
    assign fifo_empty = (level_q == '0);
    assign tri_ready  = !fifo_full && !flush;
    assign push       = tri_valid && tri_ready;

    // Round-robin search: first idle lane at or after rr_q, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        lane_idx   = 0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_idx = (int'(rr_q) + i) % NUM_LANES;
            if (!pick_found && idle_vec[lane_idx]) begin
                pick_found = 1'b1;
                pick_idx   = LW'(lane_idx);
            end
        end
    end

    assign dispatch = !fifo_empty && !flush && pick_found && (!in_order || (&idle_vec));

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        rr_d     = rr_q;
        if (push) begin
            mem_d[wr_ptr_q] = tri_in;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (dispatch) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            rr_d     = (pick_idx == LW'(NUM_LANES - 1)) ? '0 : pick_idx + LW'(1);
        end
        level_d = level_q + LVW'(push) - LVW'(dispatch);
        // Flush blocks push and dispatch, so collapsing the read pointer onto wr_ptr_q empties the queue.
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            level_d  = '0;
        end
    end

    always_comb begin
        setup_start_d = '0;
        rast_start_d  = '0;
        done_inc      = '0;
        degen_inc     = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            state_d[i]    = state_q[i];
            lane_tri_d[i] = lane_tri_q[i];
            case (state_q[i])
                L_IDLE: begin
                    if (dispatch && (pick_idx == LW'(i))) begin
                        state_d[i]       = L_SETUP;
                        setup_start_d[i] = 1'b1;
                        lane_tri_d[i]    = mem_q[rd_ptr_q];
                    end
                end
                L_SETUP: begin
                    if (setup_done[i]) begin
                        if (setup_valid[i]) begin
                            state_d[i]      = L_RAST;
                            rast_start_d[i] = 1'b1;
                        end else begin
                            state_d[i] = L_IDLE;
                            degen_inc  = degen_inc + CNT_W'(1);
                        end
                    end
                end
                L_RAST: begin
                    if (rast_done[i]) begin
                        state_d[i] = L_IDLE;
                        done_inc   = done_inc + CNT_W'(1);
                    end
                end
                default: state_d[i] = L_IDLE;
            endcase
        end
        done_cnt_d  = done_cnt_q + done_inc;
        degen_cnt_d = degen_cnt_q + degen_inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                state_q[i]    <= L_IDLE;
                lane_tri_q[i] <= '0;
            end
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                mem_q[j] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            rr_q          <= '0;
            setup_start_q <= '0;
            rast_start_q  <= '0;
            done_cnt_q    <= '0;
            degen_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            lane_tri_q    <= lane_tri_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            rr_q          <= rr_d;
            setup_start_q <= setup_start_d;
            rast_start_q  <= rast_start_d;
            done_cnt_q    <= done_cnt_d;
            degen_cnt_q   <= degen_cnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_tri[i*TRI_W +: TRI_W] = lane_tri_q[i];
        end
    end

    assign setup_start  = setup_start_q;
    assign rast_start   = rast_start_q;
    assign fifo_level   = level_q;
    assign lane_busy    = ~idle_vec;
    assign tri_done_cnt = done_cnt_q;
    assign degen_cnt    = degen_cnt_q;
    assign busy         = !fifo_empty || (|lane_busy);

endmodule
